// File: rtl/smc777_text_video.sv
// SMC-777 text-mode pixel generator: per-cell VRAM code/attr fetch, font ROM lookup, 8-pixel shifter.
// Video and all memory-side outputs are registered; video lags the hc tick by exactly one clk.
module smc777_text_video #(
  parameter int          COLS      = 64,
  parameter int          ROWS      = 25,
  parameter int          HSTART    = 8,
  parameter logic [15:0] VRAM_BASE = 16'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_pix,
  input  logic        scandouble,
  input  logic [9:0]  hc,
  input  logic [9:0]  vc,
  input  logic        vblank,
  output logic        vram_rd,
  output logic [15:0] vram_addr,
  input  logic [7:0]  vram_q,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_q,
  output logic [7:0]  video,
  output logic        fetch_overrun
);

  localparam logic [9:0]  ACTIVE_LINES = 10'(ROWS * 8);
  localparam logic [9:0]  ACTIVE_PIX   = 10'(COLS * 8);
  localparam logic [7:0]  COLS_W       = 8'(COLS);
  localparam logic [10:0] FETCH0       = 11'(HSTART - 8);
  localparam logic [10:0] PIX0         = 11'(HSTART);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CODE,
    S_ATTR,
    S_FONT,
    S_GLYPH,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [2:0]  r_scan;
  logic [7:0]  r_attr;
  logic [7:0]  r_pend_glyph;
  logic [7:0]  r_pend_attr;
  logic [7:0]  r_shift;
  logic [7:0]  r_sh_attr;
  logic [4:0]  r_frame;
  logic        r_vblank_d;

  logic [9:0]  w_line;
  logic        w_active;
  logic [10:0] w_fofs;
  logic        w_fetch_hit;
  logic        w_trigger;
  logic [6:0]  w_row;
  logic [6:0]  w_col;
  logic [15:0] w_cell;
  logic [15:0] w_code_addr;
  logic [10:0] w_xofs;
  logic        w_in_x;
  logic        w_load;
  logic [7:0]  w_glyph;
  logic [7:0]  w_attr;
  logic        w_blank;
  logic        w_on;
  logic [7:0]  w_color;

  assign w_line   = scandouble ? {1'b0, vc[9:1]} : vc;
  assign w_active = (w_line < ACTIVE_LINES);

  // Offsets are taken in 11 bits so an hc below the origin shows up as bit 10 set.
  assign w_fofs      = {1'b0, hc} - FETCH0;
  assign w_fetch_hit = !w_fofs[10] && (w_fofs[2:0] == 3'd0) && ({1'b0, w_fofs[9:3]} < COLS_W);
  assign w_trigger   = ce_pix && w_active && w_fetch_hit;

  assign w_row       = w_line[9:3];
  assign w_col       = w_fofs[9:3];
  assign w_cell      = 16'(w_row) * 16'(COLS) + 16'(w_col);
  assign w_code_addr = VRAM_BASE + (w_cell << 1);

  assign w_xofs = {1'b0, hc} - PIX0;
  assign w_in_x = !w_xofs[10] && (w_xofs[9:0] < ACTIVE_PIX);
  assign w_load = w_in_x && (w_xofs[2:0] == 3'd0);

  // Value the shifter takes on this tick; its MSB is the pixel being emitted now.
  assign w_glyph = w_load ? r_pend_glyph : {r_shift[6:0], 1'b0};
  assign w_attr  = w_load ? r_pend_attr  : r_sh_attr;
  assign w_blank = w_attr[4] & r_frame[4];
  assign w_on    = (w_glyph[7] & ~w_blank) ^ w_attr[3];
  // attr[2] drives red, attr[1] green, attr[0] blue.
  assign w_color = w_on ? {{3{w_attr[2]}}, {3{w_attr[1]}}, {2{w_attr[0]}}} : 8'h00;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_scan        <= 3'd0;
      r_attr        <= 8'h00;
      r_pend_glyph  <= 8'h00;
      r_pend_attr   <= 8'h00;
      r_shift       <= 8'h00;
      r_sh_attr     <= 8'h00;
      r_frame       <= 5'd0;
      r_vblank_d    <= 1'b0;
      vram_rd       <= 1'b0;
      vram_addr     <= 16'h0000;
      font_addr     <= 11'h000;
      video         <= 8'h00;
      fetch_overrun <= 1'b0;
    end else begin
      r_vblank_d <= vblank;
      if (vblank && !r_vblank_d) begin
        r_frame <= r_frame + 5'd1;
      end

      vram_rd <= 1'b0;
      if (w_trigger) begin
        if (r_state != S_IDLE) begin
          fetch_overrun <= 1'b1;
        end
        r_state   <= S_CODE;
        vram_rd   <= 1'b1;
        vram_addr <= w_code_addr;
        r_scan    <= w_line[2:0];
      end else begin
        case (r_state)
          S_CODE: begin
            r_state   <= S_ATTR;
            vram_rd   <= 1'b1;
            vram_addr <= vram_addr + 16'd1;
          end
          S_ATTR: begin
            r_state   <= S_FONT;
            font_addr <= {vram_q, r_scan};
          end
          S_FONT: begin
            r_state <= S_GLYPH;
            r_attr  <= vram_q;
          end
          S_GLYPH: begin
            r_state      <= S_DONE;
            r_pend_glyph <= font_q;
            r_pend_attr  <= r_attr;
          end
          default: r_state <= S_IDLE;
        endcase
      end

      if (ce_pix) begin
        video <= (w_in_x && w_active) ? w_color : 8'h00;
        if (w_in_x) begin
          r_shift   <= w_glyph;
          r_sh_attr <= w_attr;
        end
      end
    end
  end

endmodule

// File: tb/tb_smc777_text_video.sv
// Directed bench for smc777_text_video with a VRAM/font ROM model and a table of single-cell vectors.
module tb_smc777_text_video;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce_pix;
  logic        scandouble;
  logic [9:0]  hc;
  logic [9:0]  vc;
  logic        vblank;
  logic        vram_rd;
  logic [15:0] vram_addr;
  logic [7:0]  vram_q;
  logic [10:0] font_addr;
  logic [7:0]  font_q;
  logic [7:0]  video;
  logic        fetch_overrun;

  always #5 clk = ~clk;

  smc777_text_video dut (
    .clk           (clk),
    .reset         (reset),
    .ce_pix        (ce_pix),
    .scandouble    (scandouble),
    .hc            (hc),
    .vc            (vc),
    .vblank        (vblank),
    .vram_rd       (vram_rd),
    .vram_addr     (vram_addr),
    .vram_q        (vram_q),
    .font_addr     (font_addr),
    .font_q        (font_q),
    .video         (video),
    .fetch_overrun (fetch_overrun)
  );

  logic [7:0] vram     [0:65535];
  logic [7:0] font_rom [0:2047];

  // VRAM data one clk after the read strobe; font data one clk after the address.
  always @(posedge clk) begin
    if (vram_rd) vram_q <= vram[vram_addr];
    font_q <= font_rom[font_addr];
  end

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0]  vbuf [0:637];
  logic        rd_h [0:637];
  logic [15:0] ad_h [0:637];
  logic [10:0] fa_h [0:637];
  int          rdcnt;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  task automatic tick(input int h, input logic ce);
    hc     = 10'(h);
    ce_pix = ce;
    @(posedge clk);
    #1;
  endtask

  // Sweep hc 0..nhc-1; in non-scandouble mode every tick is followed by an idle clk.
  task automatic do_line(input logic [9:0] v, input logic sd, input int nhc);
    rdcnt      = 0;
    vc         = v;
    scandouble = sd;
    for (int h = 0; h < nhc; h++) begin
      tick(h, 1'b1);
      vbuf[h] = video;
      rd_h[h] = vram_rd;
      ad_h[h] = vram_addr;
      fa_h[h] = font_addr;
      if (vram_rd) rdcnt++;
      if (!sd) begin
        tick(h, 1'b0);
        if (vram_rd) rdcnt++;
      end
    end
    ce_pix = 1'b0;
  endtask

  function automatic logic [63:0] cell_px(input int h0);
    logic [63:0] r;
    r = 64'h0;
    for (int i = 0; i < 8; i++) r = {r[55:0], vbuf[h0 + i]};
    return r;
  endfunction

  task automatic pulse_vblank(input int n);
    for (int i = 0; i < n; i++) begin
      vblank = 1'b1;
      tick(0, 1'b0);
      vblank = 1'b0;
      tick(0, 1'b0);
    end
  endtask

  typedef struct {
    logic        sd;
    logic [9:0]  v;
    logic [15:0] caddr;
    logic [7:0]  code;
    logic [2:0]  scan;
    logic [7:0]  attr;
    logic [7:0]  glyph;
    logic [63:0] exp;
    int          exp_rd;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #5_000_000;
    $display("FAIL timeout: bench did not finish, got no summary, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b1, 10'd0,   16'h0000, 8'h41, 3'd0, 8'h07, 8'h18, 64'h000000FFFF000000, 128};
    vecs[1] = '{1'b1, 10'd0,   16'h0000, 8'h41, 3'd0, 8'h0C, 8'hF0, 64'h00000000E0E0E0E0, 128};
    vecs[2] = '{1'b0, 10'd3,   16'h0000, 8'h42, 3'd3, 8'h01, 8'hA5, 64'h0300030000030003, 128};
    vecs[3] = '{1'b1, 10'd37,  16'h0100, 8'h30, 3'd2, 8'h04, 8'h81, 64'hE0000000000000E0, 128};
    vecs[4] = '{1'b0, 10'd199, 16'h0C00, 8'hFF, 3'd7, 8'h07, 8'h3C, 64'h0000FFFFFFFF0000, 128};
    vecs[5] = '{1'b1, 10'd1,   16'h0000, 8'h10, 3'd0, 8'h0F, 8'h0F, 64'hFFFFFFFF00000000, 128};
    vecs[6] = '{1'b0, 10'd200, 16'h0C80, 8'h41, 3'd0, 8'h07, 8'hFF, 64'h0000000000000000, 0};
    vecs[7] = '{1'b0, 10'd401, 16'h1900, 8'h41, 3'd1, 8'h07, 8'hFF, 64'h0000000000000000, 0};
    vecs[8] = '{1'b1, 10'd400, 16'h0C80, 8'h41, 3'd0, 8'h07, 8'hFF, 64'h0000000000000000, 0};
    vecs[9] = '{1'b1, 10'd15,  16'h0000, 8'h41, 3'd7, 8'h07, 8'h7E, 64'h00FFFFFFFFFFFF00, 128};

    for (int i = 0; i < 65536; i++) vram[i] = 8'h00;
    for (int i = 0; i < 2048; i++) font_rom[i] = 8'h00;

    reset = 1'b1; ce_pix = 1'b0; scandouble = 1'b1; hc = '0; vc = '0; vblank = 1'b0;
    repeat (3) tick(0, 1'b0);
    check("reset video", video, 8'h00);
    check("reset vram_rd", vram_rd, 1'b0);
    check("reset vram_addr", vram_addr, 16'h0000);
    check("reset font_addr", font_addr, 11'h000);
    check("reset overrun", fetch_overrun, 1'b0);
    reset = 1'b0;
    tick(0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      vram[vecs[i].caddr]               = vecs[i].code;
      vram[vecs[i].caddr + 16'd1]       = vecs[i].attr;
      font_rom[{vecs[i].code, vecs[i].scan}] = vecs[i].glyph;
      do_line(vecs[i].v, vecs[i].sd, 638);
      check($sformatf("vec%0d pixels", i), cell_px(8), vecs[i].exp);
      check($sformatf("vec%0d rd count", i), 64'(rdcnt), 64'(vecs[i].exp_rd));
    end
    check("no overrun in normal lines", fetch_overrun, 1'b0);

    // Row 2: column 3 addressing and font lookup, column 63 right edge.
    vram[16'h0106] = 8'h5A; vram[16'h0107] = 8'h07; font_rom[{8'h5A, 3'd2}] = 8'hC3;
    vram[16'h017E] = 8'h5B; vram[16'h017F] = 8'h07; font_rom[{8'h5B, 3'd2}] = 8'hFF;
    do_line(10'd37, 1'b1, 638);
    check("col3 code rd", rd_h[24], 1'b1);
    check("col3 code addr", ad_h[24], 16'h0106);
    check("col3 attr addr", ad_h[25], 16'h0107);
    check("col3 rd ends", rd_h[26], 1'b0);
    check("col3 font_addr", fa_h[26], {8'h5A, 3'd2});
    check("col3 pixels", cell_px(32), 64'hFFFF00000000FFFF);
    check("col63 code addr", ad_h[504], 16'h017E);
    check("col63 pixels", cell_px(512), 64'hFFFFFFFFFFFFFFFF);
    check("x=512 blank", vbuf[520], 8'h00);
    check("x=-1 blank", vbuf[7], 8'h00);

    // Blink on bit 4 of the vblank edge counter.
    reset = 1'b1; tick(0, 1'b0); reset = 1'b0;
    vram[0] = 8'h41; vram[1] = 8'h11; font_rom[{8'h41, 3'd0}] = 8'h18;
    do_line(10'd0, 1'b1, 24);
    check("blink frame0", cell_px(8), 64'h0000000303000000);
    pulse_vblank(15);
    do_line(10'd0, 1'b1, 24);
    check("blink frame15", cell_px(8), 64'h0000000303000000);
    pulse_vblank(1);
    do_line(10'd0, 1'b1, 24);
    check("blink frame16", cell_px(8), 64'h0000000000000000);
    pulse_vblank(16);
    do_line(10'd0, 1'b1, 24);
    check("blink frame32", cell_px(8), 64'h0000000303000000);

    // Second trigger three clks into a fetch.
    vram[1] = 8'h07; font_rom[{8'h41, 3'd0}] = 8'hFF;
    reset = 1'b1; tick(0, 1'b0); reset = 1'b0;
    scandouble = 1'b1; vc = 10'd0;
    tick(0, 1'b1);
    tick(0, 1'b0);
    tick(0, 1'b0);
    check("overrun before", fetch_overrun, 1'b0);
    tick(0, 1'b1);
    check("overrun set", fetch_overrun, 1'b1);
    check("overrun restart rd", vram_rd, 1'b1);
    check("overrun restart addr", vram_addr, 16'h0000);
    tick(0, 1'b0);
    tick(0, 1'b0);
    check("overrun refetch font_addr", font_addr, {8'h41, 3'd0});
    repeat (10) tick(0, 1'b0);
    check("overrun sticky idle", fetch_overrun, 1'b1);
    do_line(10'd0, 1'b1, 24);
    check("overrun sticky line", fetch_overrun, 1'b1);
    reset = 1'b1; tick(0, 1'b0); reset = 1'b0;
    check("overrun cleared", fetch_overrun, 1'b0);
    check("overrun reset video", video, 8'h00);

    // Reset in the middle of a drawn cell and an in-flight fetch.
    tick(0, 1'b1);
    check("clean trigger rd", vram_rd, 1'b1);
    check("clean trigger addr", vram_addr, 16'h0000);
    for (int h = 1; h <= 10; h++) tick(h, 1'b1);
    check("pre-reset video", video, 8'hFF);
    reset = 1'b1;
    tick(11, 1'b1);
    check("mid reset video", video, 8'h00);
    check("mid reset rd", vram_rd, 1'b0);
    check("mid reset addr", vram_addr, 16'h0000);
    check("mid reset font_addr", font_addr, 11'h000);
    reset = 1'b0;
    for (int h = 12; h <= 14; h++) tick(h, 1'b1);
    check("post reset shifter clear", video, 8'h00);
    tick(15, 1'b1);
    tick(16, 1'b1);
    check("post reset trigger rd", vram_rd, 1'b1);
    check("post reset trigger addr", vram_addr, 16'h0004);
    check("post reset overrun", fetch_overrun, 1'b0);
    ce_pix = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
